dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder end of the core's data-memory bus. The core's Memory stage drives mem_en/mem_addr/mem_din/mem_wea/mem_rea; this block returns mem_dout and mem_hold.
- Contains a byte-lane-writable word RAM, a configurable wait-state FSM and a small MMIO window.
- The MMIO window hands transmit bytes to a UART TX controller over a valid/ready handshake.
- Sits beside the core in the SoC top, on the rbus memory signals.

Parameters:
- DEPTH, 4096, RAM size in 32-bit words (power of 2).
- WAIT_STATES, 0, mem_hold cycles per access (0..15).
- MMIO_BASE, 32'h0001_0000, MMIO window base; match on mem_addr[31:12]==MMIO_BASE[31:12].

Ports:
- clk  in  1  clock
- Rst  in  1  reset
- mem_en  in  4  byte-lane enables; 0 = no request
- mem_addr  in  32  byte address; word index = mem_addr[log2(DEPTH)+1:2]
- mem_din  in  32  write data, lane-aligned
- mem_wea  in  1  write request
- mem_rea  in  1  read request
- mem_dout  out  32  read data (full word; core extracts lanes)
- mem_hold  out  1  stall core pipeline
- tx_data  out  8  byte to UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts byte
- err  out  1  sticky out-of-range access flag

Behaviour:
- Reset: Rst is synchronous, active-high; clock is clk. On reset, outputs go to mem_dout=0, mem_hold=0, tx_valid=0, tx_data=0, err=0; FSM goes to IDLE; cnt=0. RAM contents are not cleared.
- Request: req = (mem_wea|mem_rea) & (mem_en!=0). If both wea and rea are set, the write wins and mem_dout is unchanged. The core holds request lines stable while mem_hold=1.
- Target decode:
  - MMIO when mem_addr[31:12] matches MMIO_BASE.
  - RAM when word index < DEPTH, i.e. mem_addr[31:2] < DEPTH.
  - Otherwise OOR.
- txblock = target is TXDATA write & tx_valid & ~tx_ready.
- FSM states IDLE, WAIT, DONE.
- IDLE:
  - No req: stay.
  - req with WAIT_STATES==0 and ~txblock: perform the access at this edge and stay IDLE. mem_hold=0.
  - req with WAIT_STATES==1, or WAIT_STATES==0 with txblock: go to DONE if WAIT_STATES==1 & ~txblock, else WAIT with cnt=0. mem_hold=1.
  - req with WAIT_STATES>=2: go to WAIT with cnt=WAIT_STATES-2. mem_hold=1.
- WAIT: mem_hold=1. Decrement cnt until 0. Go to DONE when cnt==0 & ~txblock.
- DONE:
  - mem_hold=0.
  - Perform the access at this edge.
  - Go to IDLE without re-accepting the still-present request.
- mem_hold is combinational: (IDLE & req & (WAIT_STATES>0 | txblock)) | WAIT. Total hold cycles = WAIT_STATES, plus TX backpressure cycles.
- Access effects:
  - RAM write: lanes with mem_en[i]=1 take mem_din[8i+7:8i].
  - RAM read: word registered into mem_dout. Valid the cycle after the access edge and held until the next read.
  - OOR: read returns 0, write is ignored, err<=1.
- MMIO TXDATA (offset 0x0), write: tx_data<=mem_din[7:0], tx_valid<=1. The tx_valid&tx_ready edge clears tx_valid unless a new TXDATA write lands on the same edge, in which case tx_valid stays 1 with new data.
- MMIO STATUS (offset 0x4):
  - Read returns {30'b0, err, tx_valid}.
  - A write with mem_din[1]=1 clears err. Clear and a new OOR error on the same edge: set wins.
- Other MMIO offsets: read 0, write ignored, no error.
- Reset mid-access: the pending request is dropped and not performed. The core re-presents it.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- Defined: MMIO window decoded as above.
- Undefined: no MMIO decode. All addresses map to RAM via word index modulo DEPTH, so OOR and err never occur. tx_data=0, tx_valid=0 constant, tx_ready ignored, txblock=0.

Test Plan:
1. WAIT_STATES=0: write 0xDEADBEEF to 0x10 with mem_en=4'hF, then read 0x10 -> mem_hold never high; mem_dout=0xDEADBEEF the cycle after the read edge.
2. Byte lanes: after test 1, write 0x00005500 to 0x10 with mem_en=4'b0010, then read -> 0xDEAD55EF.
3. WAIT_STATES=3: read request held -> mem_hold high exactly 3 cycles, then low 1 cycle (DONE); data valid the next cycle; exactly one access performed.
4. TX (MMIO_EN): write 0x41 to TXDATA with tx_ready=0 -> tx_valid=1, tx_data=0x41. A second write of 0x42 holds mem_hold=1 until tx_ready pulses; then tx_data=0x42, tx_valid=1.
5. OOR: read mem_addr=DEPTH*4 -> mem_dout=0, err=1; STATUS read=0x2; STATUS write 0x2 -> err=0.
6. Reset in WAIT (WAIT_STATES=4, write pending) -> mem_hold=0 next cycle; RAM word unchanged; tx_valid=0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory bus responder: byte-lane RAM, wait-state FSM and, when DMEM_MMIO_EN is
// defined, an MMIO window (TXDATA/STATUS) feeding a UART TX valid/ready handshake.
module dmem_responder #(
    parameter int          DEPTH       = 4096,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] MMIO_BASE   = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [3:0]  mem_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_din,
    input  logic        mem_wea,
    input  logic        mem_rea,
    output logic [31:0] mem_dout,
    output logic        mem_hold,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_next;

    logic            w_req;
    logic            w_wr;
    logic            w_rd;
    logic            w_ram;
    logic            w_status;
    logic            w_txblock;
    logic [31:0]     w_status_word;
    logic            w_hold;
    logic            w_fsm_access;
    logic            w_access;
    logic [AW-1:0]   w_idx;
    logic [31:0]     w_ram_q;
    logic            r_sel_ram;
    logic [31:0]     r_dout_other;
    logic            w_unused;

    // Write wins when both strobes are set; the read side then leaves mem_dout alone.
    assign w_req = (mem_wea | mem_rea) & (mem_en != 4'b0000);
    assign w_wr  = mem_wea;
    assign w_rd  = mem_rea & ~mem_wea;
    assign w_idx = mem_addr[AW+1:2];

    assign w_unused = ^{mem_addr, tx_ready, MMIO_BASE};

`ifdef DMEM_MMIO_EN
    logic       w_mmio;
    logic       w_oor;
    logic       w_txdata;
    logic       r_err;
    logic       r_tx_valid;
    logic [7:0] r_tx_data;

    assign w_mmio        = (mem_addr[31:12] == MMIO_BASE[31:12]);
    assign w_ram         = ~w_mmio & ({2'b00, mem_addr[31:2]} < 32'(DEPTH));
    assign w_oor         = ~w_mmio & ~w_ram;
    assign w_txdata      = w_mmio & (mem_addr[11:2] == 10'd0);
    assign w_status      = w_mmio & (mem_addr[11:2] == 10'd1);
    assign w_txblock     = w_req & w_wr & w_txdata & r_tx_valid & ~tx_ready;
    assign w_status_word = {30'b0, r_err, r_tx_valid};

    // A TXDATA write landing on the handshake edge overrides the clear; an OOR set beats a clear.
    always_ff @(posedge clk) begin
        if (Rst) begin
            r_err      <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            if (r_tx_valid & tx_ready) begin
                r_tx_valid <= 1'b0;
            end
            if (w_access & w_wr & w_txdata) begin
                r_tx_data  <= mem_din[7:0];
                r_tx_valid <= 1'b1;
            end
            if (w_access & w_wr & w_status & mem_din[1]) begin
                r_err <= 1'b0;
            end
            if (w_access & w_oor) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err      = r_err;
    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
`else
    // Without the window every address folds onto the RAM modulo DEPTH.
    assign w_ram         = 1'b1;
    assign w_status      = 1'b0;
    assign w_txblock     = 1'b0;
    assign w_status_word = 32'd0;
    assign err           = 1'b0;
    assign tx_valid      = 1'b0;
    assign tx_data       = 8'h00;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_hold       = 1'b0;
        w_fsm_access = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (WAIT_STATES == 0 && !w_txblock) begin
                        w_fsm_access = 1'b1;
                    end else begin
                        w_hold = 1'b1;
                        if (WAIT_STATES >= 2) begin
                            w_state_next = S_WAIT;
                            w_cnt_next   = 4'(WAIT_STATES - 2);
                        end else if (WAIT_STATES == 1 && !w_txblock) begin
                            w_state_next = S_DONE;
                        end else begin
                            w_state_next = S_WAIT;
                            w_cnt_next   = 4'd0;
                        end
                    end
                end
            end
            S_WAIT: begin
                w_hold = 1'b1;
                if (r_cnt != 4'd0) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else if (!w_txblock) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // The core still presents the request here; it is performed once, not re-accepted.
                w_fsm_access = w_req;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign mem_hold = w_hold & ~Rst;
    assign w_access = w_fsm_access & ~Rst;

    // One 8-bit RAM per byte lane so each lane keeps its own write enable.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_q;

        always_ff @(posedge clk) begin
            if (w_access & w_wr & w_ram & mem_en[gi]) begin
                r_mem[w_idx] <= mem_din[8*gi +: 8];
            end
            if (w_access & w_rd & w_ram) begin
                r_q <= r_mem[w_idx];
            end
        end

        assign w_ram_q[8*gi +: 8] = r_q;
    end

    // Read source is remembered so the RAM output register needs no reset.
    always_ff @(posedge clk) begin
        if (Rst) begin
            r_sel_ram    <= 1'b0;
            r_dout_other <= 32'd0;
        end else if (w_access & w_rd) begin
            r_sel_ram    <= w_ram;
            r_dout_other <= w_status ? w_status_word : 32'd0;
        end
    end

    assign mem_dout = r_sel_ram ? w_ram_q : r_dout_other;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 3 and 4 wait states) checked against a
// word-level model every cycle, plus literal expectations for the directed cases.
module tb_dmem_responder;

    localparam int          DEPTH = 256;
    localparam logic [31:0] MB    = 32'h0001_0000;
    localparam int          ND    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [ND];
    logic [3:0]  en   [ND];
    logic [31:0] addr [ND];
    logic [31:0] din  [ND];
    logic        wea  [ND];
    logic        rea  [ND];
    logic        rdy  [ND];
    logic [31:0] dout [ND];
    logic        hold [ND];
    logic        txv  [ND];
    logic        err  [ND];
    logic [7:0]  txd  [ND];

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        dmem_responder #(
            .DEPTH      (DEPTH),
            .WAIT_STATES(gi == 0 ? 0 : (gi == 1 ? 3 : 4)),
            .MMIO_BASE  (MB)
        ) u_dut (
            .clk     (clk),
            .Rst     (rst[gi]),
            .mem_en  (en[gi]),
            .mem_addr(addr[gi]),
            .mem_din (din[gi]),
            .mem_wea (wea[gi]),
            .mem_rea (rea[gi]),
            .mem_dout(dout[gi]),
            .mem_hold(hold[gi]),
            .tx_data (txd[gi]),
            .tx_valid(txv[gi]),
            .tx_ready(rdy[gi]),
            .err     (err[gi])
        );
    end

    // Behavioural model state
    logic [31:0] m_dout [ND];
    logic        m_err  [ND];
    logic        m_txv  [ND];
    logic [7:0]  m_txd  [ND];
    logic [31:0] m_mem  [ND][DEPTH];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
        end
    endtask

    // Every clock edge goes through here so the model sees each tx handshake.
    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            if (m_txv[d] && rdy[d]) m_txv[d] = 1'b0;
        end
    endtask

    task automatic m_apply(int d, bit wr, bit rd, logic [3:0] e, logic [31:0] a,
                           logic [31:0] dn, bit s_err, bit s_txv);
        int w;
        w = int'(a >> 2);
        if (!(wr || rd) || e == 4'h0) return;
`ifdef DMEM_MMIO_EN
        if ((a >> 12) == (MB >> 12)) begin
            if (wr) begin
                if ((a & 32'hFFC) == 0) begin
                    m_txd[d] = dn[7:0];
                    m_txv[d] = 1'b1;
                end else if ((a & 32'hFFC) == 4 && dn[1]) begin
                    m_err[d] = 1'b0;
                end
            end else begin
                m_dout[d] = ((a & 32'hFFC) == 4) ? {30'b0, s_err, s_txv} : 32'd0;
            end
            return;
        end
        if ((a >> 2) >= DEPTH) begin
            m_err[d] = 1'b1;
            if (!wr) m_dout[d] = 32'd0;
            return;
        end
`else
        w = w % DEPTH;
`endif
        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                if (e[i]) m_mem[d][w][8*i +: 8] = dn[8*i +: 8];
            end
        end else begin
            m_dout[d] = m_mem[d][w];
        end
    endtask

    // Core-side access: hold the request until mem_hold is low, then the next edge completes it.
    task automatic access(int d, bit wr, bit rd, logic [3:0] e, logic [31:0] a,
                          logic [31:0] dn, int exp_hold, int rdy_at);
        int h;
        bit se, sv, done;
        h = 0;
        done = 1'b0;
        wea[d] = wr; rea[d] = rd; en[d] = e; addr[d] = a; din[d] = dn;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            rdy[d] = (cyc == rdy_at);
            @(negedge clk);
            se = m_err[d];
            sv = m_txv[d];
            if (hold[d]) begin
                h++;
                tick();
            end else begin
                tick();
                m_apply(d, wr, rd, e, a, dn, se, sv);
                done = 1'b1;
            end
            #1;
        end
        wea[d] = 1'b0; rea[d] = 1'b0; en[d] = 4'h0; rdy[d] = 1'b0;
        $display("access dut%0d wr=%0d rd=%0d en=%h addr=%h din=%h hold=%0d dout=%h",
                 d, wr, rd, e, a, dn, h, dout[d]);
        chk("hold_cycles", d, 32'(h), 32'(exp_hold));
    endtask

    task automatic idle(int d, int n, bit r);
        for (int i = 0; i < n; i++) begin
            rdy[d] = r;
            tick();
            #1;
        end
        rdy[d] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < ND; d++) begin
                chk("dout", d, dout[d], m_dout[d]);
                chk("err", d, {31'b0, err[d]}, {31'b0, m_err[d]});
                chk("tx_valid", d, {31'b0, txv[d]}, {31'b0, m_txv[d]});
                chk("tx_data", d, {24'b0, txd[d]}, {24'b0, m_txd[d]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b1; en[d] = 4'h0; addr[d] = 32'd0; din[d] = 32'd0;
            wea[d] = 1'b0; rea[d] = 1'b0; rdy[d] = 1'b0;
            m_dout[d] = 32'd0; m_err[d] = 1'b0; m_txv[d] = 1'b0; m_txd[d] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("rst_dout", d, dout[d], 32'd0);
            chk("rst_hold", d, {31'b0, hold[d]}, 32'd0);
            chk("rst_err", d, {31'b0, err[d]}, 32'd0);
            chk("rst_txv", d, {31'b0, txv[d]}, 32'd0);
            chk("rst_txd", d, {24'b0, txd[d]}, 32'd0);
        end
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // Zero wait states: full word, byte lane, write-wins, no-request cases
        access(0, 1, 0, 4'hF, 32'h10, 32'hDEADBEEF, 0, -1);
        access(0, 0, 1, 4'hF, 32'h10, 32'h0, 0, -1);
        chk("t1_read", 0, dout[0], 32'hDEADBEEF);
        access(0, 1, 0, 4'b0010, 32'h10, 32'h0000_5500, 0, -1);
        access(0, 0, 1, 4'hF, 32'h10, 32'h0, 0, -1);
        chk("t2_lane", 0, dout[0], 32'hDEAD55EF);
        access(0, 1, 1, 4'b1000, 32'h10, 32'h7700_0000, 0, -1);
        chk("wr_wins_dout", 0, dout[0], 32'hDEAD55EF);
        access(0, 0, 1, 4'hF, 32'h10, 32'h0, 0, -1);
        chk("wr_wins_mem", 0, dout[0], 32'h77AD55EF);
        access(0, 1, 0, 4'h0, 32'h10, 32'hFFFF_FFFF, 0, -1);
        access(0, 0, 1, 4'h0, 32'h3FC, 32'h0, 0, -1);
        chk("noreq_dout", 0, dout[0], 32'h77AD55EF);
        access(0, 1, 0, 4'hF, 32'h3FC, 32'h0102_0304, 0, -1);
        access(0, 0, 1, 4'hF, 32'h3FC, 32'h0, 0, -1);
        chk("last_word", 0, dout[0], 32'h0102_0304);
        access(0, 0, 1, 4'hF, 32'h10, 32'h0, 0, -1);
        chk("noreq_mem", 0, dout[0], 32'h77AD55EF);

        // Three wait states
        access(1, 1, 0, 4'hF, 32'h40, 32'h0BAD_CAFE, 3, -1);
        access(1, 0, 1, 4'hF, 32'h40, 32'h0, 3, -1);
        chk("t3_read", 1, dout[1], 32'h0BAD_CAFE);

        // Four wait states, reset while a write is waiting
`ifdef DMEM_MMIO_EN
        access(2, 1, 0, 4'hF, MB, 32'h77, 4, -1);
`endif
        access(2, 1, 0, 4'hF, 32'h20, 32'hCAFE_F00D, 4, -1);
        wea[2] = 1'b1; en[2] = 4'hF; addr[2] = 32'h20; din[2] = 32'h1111_1111;
        @(negedge clk);
        chk("t6_hold0", 2, {31'b0, hold[2]}, 32'd1);
        tick();
        #1;
        @(negedge clk);
        chk("t6_hold1", 2, {31'b0, hold[2]}, 32'd1);
        tick();
        #1;
        rst[2] = 1'b1;
        tick();
        m_dout[2] = 32'd0; m_err[2] = 1'b0; m_txv[2] = 1'b0; m_txd[2] = 8'h00;
        #1;
        rst[2] = 1'b0; wea[2] = 1'b0; en[2] = 4'h0;
        @(negedge clk);
        chk("t6_hold_after_rst", 2, {31'b0, hold[2]}, 32'd0);
        chk("t6_txv_after_rst", 2, {31'b0, txv[2]}, 32'd0);
        tick();
        #1;
        access(2, 0, 1, 4'hF, 32'h20, 32'h0, 4, -1);
        chk("t6_ram_kept", 2, dout[2], 32'hCAFE_F00D);

`ifdef DMEM_MMIO_EN
        // TX handshake and backpressure
        access(0, 1, 0, 4'hF, MB, 32'h41, 0, -1);
        chk("t4_txd41", 0, {24'b0, txd[0]}, 32'h41);
        chk("t4_txv41", 0, {31'b0, txv[0]}, 32'd1);
        access(0, 1, 0, 4'hF, MB, 32'h42, 4, 3);
        chk("t4_txd42", 0, {24'b0, txd[0]}, 32'h42);
        chk("t4_txv42", 0, {31'b0, txv[0]}, 32'd1);
        access(0, 0, 1, 4'hF, MB + 32'h4, 32'h0, 0, -1);
        chk("status_txv", 0, dout[0], 32'h1);
        access(0, 1, 0, 4'hF, MB, 32'h43, 0, 0);
        chk("tx_same_edge_v", 0, {31'b0, txv[0]}, 32'd1);
        chk("tx_same_edge_d", 0, {24'b0, txd[0]}, 32'h43);
        idle(0, 1, 1'b1);
        access(1, 1, 0, 4'hF, MB, 32'h50, 3, -1);
        access(1, 1, 0, 4'hF, MB, 32'h51, 6, 5);
        chk("ws3_backpressure", 1, {24'b0, txd[1]}, 32'h51);

        // Out-of-range and status register
        access(0, 0, 1, 4'hF, DEPTH * 4, 32'h0, 0, -1);
        chk("t5_oor_dout", 0, dout[0], 32'h0);
        chk("t5_oor_err", 0, {31'b0, err[0]}, 32'd1);
        access(0, 0, 1, 4'hF, MB + 32'h4, 32'h0, 0, -1);
        chk("t5_status", 0, dout[0], 32'h2);
        access(0, 1, 0, 4'hF, MB + 32'h8, 32'h2, 0, -1);
        access(0, 0, 1, 4'hF, MB + 32'h8, 32'h0, 0, -1);
        chk("other_off", 0, dout[0], 32'h0);
        chk("other_off_err", 0, {31'b0, err[0]}, 32'd1);
        access(0, 1, 0, 4'hF, MB + 32'h4, 32'h2, 0, -1);
        chk("t5_clear", 0, {31'b0, err[0]}, 32'd0);
        access(0, 1, 0, 4'hF, DEPTH * 4 + 8, 32'h1234_5678, 0, -1);
        chk("oor_wr_err", 0, {31'b0, err[0]}, 32'd1);
`else
        // Addresses past DEPTH alias onto the RAM
        access(0, 1, 0, 4'hF, DEPTH * 4 + 32'h14, 32'hA5A5_5A5A, 0, -1);
        access(0, 0, 1, 4'hF, 32'h14, 32'h0, 0, -1);
        chk("alias_read", 0, dout[0], 32'hA5A5_5A5A);
        access(1, 1, 0, 4'hF, MB + 32'h4, 32'h0000_0002, 3, -1);
        access(1, 0, 1, 4'hF, 32'h4, 32'h0, 3, -1);
        chk("mmio_is_ram", 1, dout[1], 32'h0000_0002);
        chk("no_err", 1, {31'b0, err[1]}, 32'd0);
`endif

        idle(0, 2, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
